// File: rtl/fe_redirect_ctrl.sv
// Front-end redirect sequencer: arbitrates exception/branch/jump redirects, then runs
// stall, FIFO flush, drain and map restore before a one-cycle PC override. Optional macro: FE_REDIRECT_STATS_EN.
module fe_redirect_ctrl #(
  parameter int PC_WIDTH        = 32,
  parameter int DRAIN_CYCLES    = 2,
  parameter int RESTORE_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                exc_req,
  input  logic [PC_WIDTH-1:0] exc_pc,
  input  logic                br_req,
  input  logic [PC_WIDTH-1:0] br_pc,
  input  logic                jmp_req,
  input  logic [PC_WIDTH-1:0] jmp_pc,
  output logic                exc_ack,
  output logic                br_ack,
  output logic                jmp_ack,
  input  logic                map_restore_done,
  output logic                map_restore_req,
  output logic                fe_stall,
  output logic                fifo_flush,
  output logic                redir_exception,
  output logic                redir_branch,
  output logic                redir_jump,
  output logic [PC_WIDTH-1:0] pc_override,
  output logic                busy,
  output logic                restore_timeout
`ifdef FE_REDIRECT_STATS_EN
  ,
  output logic [15:0]         stat_exc,
  output logic [15:0]         stat_br,
  output logic [15:0]         stat_jmp
`endif
);

  localparam int TMO_W = $clog2(RESTORE_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RESTORE_TIMEOUT - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(RESTORE_TIMEOUT);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_FLUSH    = 3'd1;
  localparam logic [2:0] S_DRAIN    = 3'd2;
  localparam logic [2:0] S_RESTORE  = 3'd3;
  localparam logic [2:0] S_REDIRECT = 3'd4;

  localparam logic [1:0] C_NONE = 2'd0;
  localparam logic [1:0] C_EXC  = 2'd1;
  localparam logic [1:0] C_BR   = 2'd2;
  localparam logic [1:0] C_JMP  = 2'd3;

  logic [2:0]          state;
  logic [1:0]          cause;
  logic [PC_WIDTH-1:0] pc_q;
  logic [3:0]          drain_cnt;
  logic [TMO_W-1:0]    tmo_cnt;
  logic                tmo_flag;
  logic                exc_win, br_win, jmp_win, preempt, in_seq;

  assign in_seq = (state == S_FLUSH) || (state == S_DRAIN) || (state == S_RESTORE);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    exc_win = 1'b0;
    br_win  = 1'b0;
    jmp_win = 1'b0;
    if (state == S_IDLE) begin
      exc_win = exc_req;
      br_win  = !exc_req && br_req;
      jmp_win = !exc_req && !br_req && jmp_req;
    end else if (in_seq && cause != C_EXC) begin
      exc_win = exc_req;
    end
  end

  assign preempt = exc_win && (state != S_IDLE);

  // Acks are gated by reset so a request held through reset shows no ack.
  assign exc_ack = exc_win && rst_n;
  assign br_ack  = br_win  && rst_n;
  assign jmp_ack = jmp_win && rst_n;

  // NOTE: sequential state uses non-blocking assignments only; the whole FSM,
  // latched target and counters are async-reset so an aborted sequence leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cause     <= C_NONE;
      pc_q      <= '0;
      drain_cnt <= '0;
      tmo_cnt   <= '0;
      tmo_flag  <= 1'b0;
    end else begin
      if (exc_win) begin
        cause <= C_EXC;
        pc_q  <= exc_pc;
      end else if (br_win) begin
        cause <= C_BR;
        pc_q  <= br_pc;
      end else if (jmp_win) begin
        cause <= C_JMP;
        pc_q  <= jmp_pc;
      end

      // Timeout counter only runs inside RESTORE and saturates at the terminal value.
      if (state == S_RESTORE && !preempt)
        tmo_cnt <= (tmo_cnt == TMO_MAX) ? tmo_cnt : tmo_cnt + 1'b1;
      else
        tmo_cnt <= '0;

      if (preempt) begin
        state <= S_FLUSH;
      end else begin
        case (state)
          S_IDLE:     if (exc_win || br_win || jmp_win) state <= S_FLUSH;
          S_FLUSH: begin
            drain_cnt <= 4'(DRAIN_CYCLES - 1);
            state     <= S_DRAIN;
          end
          S_DRAIN: begin
            if (drain_cnt == 4'd0) state <= S_RESTORE;
            else                   drain_cnt <= drain_cnt - 1'b1;
          end
          S_RESTORE: begin
            if (map_restore_done) begin
              state <= S_REDIRECT;
            end else if (tmo_cnt == TMO_LAST) begin
              tmo_flag <= 1'b1;
              state    <= S_REDIRECT;
            end
          end
          S_REDIRECT: state <= S_IDLE;
          default:    state <= S_IDLE;
        endcase
      end
    end
  end

  assign busy            = (state != S_IDLE);
  assign fe_stall        = in_seq;
  assign fifo_flush      = (state == S_FLUSH);
  assign map_restore_req = (state == S_RESTORE) && (tmo_cnt == '0);
  assign redir_exception = (state == S_REDIRECT) && (cause == C_EXC);
  assign redir_branch    = (state == S_REDIRECT) && (cause == C_BR);
  assign redir_jump      = (state == S_REDIRECT) && (cause == C_JMP);
  assign pc_override     = (state == S_REDIRECT) ? pc_q : '0;
  assign restore_timeout = tmo_flag;

`ifdef FE_REDIRECT_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_exc <= '0;
      stat_br  <= '0;
      stat_jmp <= '0;
    end else begin
      if (redir_exception && stat_exc != 16'hFFFF) stat_exc <= stat_exc + 1'b1;
      if (redir_branch    && stat_br  != 16'hFFFF) stat_br  <= stat_br  + 1'b1;
      if (redir_jump      && stat_jmp != 16'hFFFF) stat_jmp <= stat_jmp + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fe_redirect_ctrl.sv
// Self-checking bench for fe_redirect_ctrl: directed sequences with literal checks plus
// a per-cycle comparison against a timeline model of the redirect sequence.
module tb_fe_redirect_ctrl;

  localparam int PCW   = 32;
  localparam int DRAIN = 2;
  localparam int TMO   = 15;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           exc_req = 1'b0, br_req = 1'b0, jmp_req = 1'b0;
  logic [PCW-1:0] exc_pc = '0, br_pc = '0, jmp_pc = '0;
  logic           map_restore_done = 1'b0;
  logic           exc_ack, br_ack, jmp_ack, map_restore_req, fe_stall, fifo_flush;
  logic           redir_exception, redir_branch, redir_jump, busy, restore_timeout;
  logic [PCW-1:0] pc_override;
`ifdef FE_REDIRECT_STATS_EN
  logic [15:0]    stat_exc, stat_br, stat_jmp;
`endif

  fe_redirect_ctrl #(.PC_WIDTH(PCW), .DRAIN_CYCLES(DRAIN), .RESTORE_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .exc_req(exc_req), .exc_pc(exc_pc),
    .br_req(br_req), .br_pc(br_pc),
    .jmp_req(jmp_req), .jmp_pc(jmp_pc),
    .exc_ack(exc_ack), .br_ack(br_ack), .jmp_ack(jmp_ack),
    .map_restore_done(map_restore_done), .map_restore_req(map_restore_req),
    .fe_stall(fe_stall), .fifo_flush(fifo_flush),
    .redir_exception(redir_exception), .redir_branch(redir_branch), .redir_jump(redir_jump),
    .pc_override(pc_override), .busy(busy), .restore_timeout(restore_timeout)
`ifdef FE_REDIRECT_STATS_EN
    , .stat_exc(stat_exc), .stat_br(stat_br), .stat_jmp(stat_jmp)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- timeline model ----------------
  // A sequence starts at the acceptance cycle; its phase is the distance from that cycle.
  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  bit       m_active = 1'b0;
  int       m_start = 0, m_red = -1, m_cause = 0;
  bit [31:0] m_pc = '0;
  bit       m_tmo = 1'b0;
  int       m_st_exc = 0, m_st_br = 0, m_st_jmp = 0;
  int       t, k;
  bit       ph_flush, ph_drain, ph_rest, ph_red;
  bit       e_exc_ack, e_br_ack, e_jmp_ack;

  always @(negedge clk) begin
    ph_flush = 0; ph_drain = 0; ph_rest = 0; ph_red = 0;
    e_exc_ack = 0; e_br_ack = 0; e_jmp_ack = 0;
    if (!rst_n) begin
      m_active = 0; m_tmo = 0; m_red = -1;
      m_st_exc = 0; m_st_br = 0; m_st_jmp = 0;
    end else begin
      t        = cyc - m_start;
      ph_flush = m_active && t == 1;
      ph_drain = m_active && t >= 2 && t <= DRAIN + 1;
      ph_rest  = m_active && t >= DRAIN + 2 && (m_red < 0 || cyc < m_red);
      ph_red   = m_active && m_red >= 0 && cyc == m_red;
      e_exc_ack = exc_req && (!m_active || ((ph_flush || ph_drain || ph_rest) && m_cause != 1));
      e_br_ack  = !m_active && !exc_req && br_req;
      e_jmp_ack = !m_active && !exc_req && !br_req && jmp_req;
    end

    check("cmp_exc_ack", exc_ack, e_exc_ack);
    check("cmp_br_ack", br_ack, e_br_ack);
    check("cmp_jmp_ack", jmp_ack, e_jmp_ack);
    check("cmp_busy", busy, m_active && rst_n);
    check("cmp_fe_stall", fe_stall, ph_flush || ph_drain || ph_rest);
    check("cmp_fifo_flush", fifo_flush, ph_flush);
    check("cmp_map_restore_req", map_restore_req, ph_rest && (cyc == m_start + DRAIN + 2));
    check("cmp_redir_exception", redir_exception, ph_red && m_cause == 1);
    check("cmp_redir_branch", redir_branch, ph_red && m_cause == 2);
    check("cmp_redir_jump", redir_jump, ph_red && m_cause == 3);
    if (ph_red) check("cmp_pc_override", pc_override, m_pc);
    check("cmp_restore_timeout", restore_timeout, m_tmo);
`ifdef FE_REDIRECT_STATS_EN
    check("cmp_stat_exc", stat_exc, m_st_exc);
    check("cmp_stat_br", stat_br, m_st_br);
    check("cmp_stat_jmp", stat_jmp, m_st_jmp);
`endif

    if (rst_n) begin
      if (e_exc_ack) begin
        m_active = 1; m_start = cyc; m_cause = 1; m_pc = exc_pc; m_red = -1;
      end else if (e_br_ack) begin
        m_active = 1; m_start = cyc; m_cause = 2; m_pc = br_pc; m_red = -1;
      end else if (e_jmp_ack) begin
        m_active = 1; m_start = cyc; m_cause = 3; m_pc = jmp_pc; m_red = -1;
      end else if (ph_rest) begin
        k = cyc - (m_start + DRAIN + 2);
        if (map_restore_done || k >= TMO - 1) begin
          m_red = cyc + 1;
          if (!map_restore_done) m_tmo = 1;
        end
      end else if (ph_red) begin
        if (m_cause == 1 && m_st_exc < 65535) m_st_exc++;
        if (m_cause == 2 && m_st_br  < 65535) m_st_br++;
        if (m_cause == 3 && m_st_jmp < 65535) m_st_jmp++;
        m_active = 0;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      tick();
      #1;
      if (!busy) break;
    end
    check("wait_idle", busy, 1'b0);
  endtask

  int  n_stall;
  bit  found, saw_jump;

  initial begin : main
    #3;
    check("rst_busy", busy, 1'b0);
    check("rst_fe_stall", fe_stall, 1'b0);
    check("rst_pc_override", pc_override, 32'h0);
    check("rst_restore_timeout", restore_timeout, 1'b0);
    tick(); tick();
    rst_n = 1'b1;

    // 1: single branch redirect, restore done immediately
    tick(); br_req = 1; br_pc = 32'h0000_0400; map_restore_done = 1; #1;
    check("t1_br_ack", br_ack, 1'b1);
    check("t1_busy_n", busy, 1'b0);
    tick(); br_req = 0; #1;
    check("t1_flush_n1", fifo_flush, 1'b1);
    check("t1_stall_n1", fe_stall, 1'b1);
    tick(); #1;
    check("t1_flush_n2", fifo_flush, 1'b0);
    check("t1_stall_n2", fe_stall, 1'b1);
    tick(); #1;
    check("t1_stall_n3", fe_stall, 1'b1);
    check("t1_mreq_n3", map_restore_req, 1'b0);
    tick(); #1;
    check("t1_mreq_n4", map_restore_req, 1'b1);
    check("t1_stall_n4", fe_stall, 1'b1);
    tick(); #1;
    check("t1_redir_n5", redir_branch, 1'b1);
    check("t1_pc_n5", pc_override, 32'h400);
    check("t1_stall_n5", fe_stall, 1'b0);
    tick(); #1;
    check("t1_busy_n6", busy, 1'b0);

    // 2: simultaneous requests, exception wins, branch then jump follow
    tick(); exc_req = 1; br_req = 1; jmp_req = 1;
    exc_pc = 32'h100; br_pc = 32'h500; jmp_pc = 32'h600; #1;
    check("t2_exc_ack", exc_ack, 1'b1);
    check("t2_br_ack", br_ack, 1'b0);
    check("t2_jmp_ack", jmp_ack, 1'b0);
    tick(); exc_req = 0; #1;
    check("t2_br_held_noack", br_ack, 1'b0);
    tick(); tick(); tick(); tick(); #1;
    check("t2_redir_exc", redir_exception, 1'b1);
    check("t2_pc", pc_override, 32'h100);
    tick(); #1;
    check("t2_br_ack_idle", br_ack, 1'b1);
    tick(); br_req = 0;
    wait_idle(20);
    check("t2_jmp_ack_idle", jmp_ack, 1'b1);
    tick(); jmp_req = 0;
    wait_idle(20);

    // 3: jump preempted by exception during DRAIN
    saw_jump = 0;
    tick(); jmp_req = 1; jmp_pc = 32'h700; #1;
    check("t3_jmp_ack", jmp_ack, 1'b1);
    tick(); jmp_req = 0;
    tick(); exc_req = 1; exc_pc = 32'h200; #1;
    check("t3_exc_ack_drain", exc_ack, 1'b1);
    tick(); #1;
    check("t3_reflush", fifo_flush, 1'b1);
    check("t3_no_self_preempt", exc_ack, 1'b0);
    tick(); exc_req = 0;
    for (int i = 0; i < 3; i++) begin
      #1; saw_jump |= redir_jump;
      tick();
    end
    #1;
    check("t3_redir_exc", redir_exception, 1'b1);
    check("t3_pc", pc_override, 32'h200);
    saw_jump |= redir_jump;
    check("t3_no_redir_jump", saw_jump, 1'b0);
    wait_idle(20);

    // 4: restore never completes, timeout path
    check("t4_tmo_before", restore_timeout, 1'b0);
    tick(); br_req = 1; br_pc = 32'h800; map_restore_done = 0; #1;
    check("t4_br_ack", br_ack, 1'b1);
    tick(); br_req = 0; #1;
    n_stall = 0; found = 0;
    for (int i = 0; i < 40; i++) begin
      if (redir_branch) begin found = 1; break; end
      if (fe_stall) n_stall++;
      tick(); #1;
    end
    check("t4_redirect_seen", found, 1'b1);
    check("t4_stall_cycles", n_stall, 18);
    check("t4_pc", pc_override, 32'h800);
    check("t4_tmo_flag", restore_timeout, 1'b1);
    tick(); #1;
    check("t4_tmo_sticky", restore_timeout, 1'b1);

    // 5: reset during RESTORE with the request held
    tick(); br_req = 1; br_pc = 32'h900; #1;
    check("t5_br_ack", br_ack, 1'b1);
    tick(); tick(); tick(); tick(); #1;
    check("t5_in_restore", map_restore_req, 1'b1);
    #1; rst_n = 0; #1;
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_stall", fe_stall, 1'b0);
    check("t5_rst_mreq", map_restore_req, 1'b0);
    check("t5_rst_ack", br_ack, 1'b0);
    check("t5_rst_tmo", restore_timeout, 1'b0);
    tick(); tick(); rst_n = 1; #1;
    check("t5_reack", br_ack, 1'b1);
    check("t5_no_strobe", redir_branch, 1'b0);
    tick(); br_req = 0; map_restore_done = 1;
    wait_idle(20);

    // 6: three branches, then a jump preempted in FLUSH by an exception
    tick(); rst_n = 0;
    tick(); rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      tick(); br_req = 1; br_pc = 32'h1000 + 32'(i * 4);
      tick(); br_req = 0;
      wait_idle(20);
    end
    tick(); jmp_req = 1; jmp_pc = 32'h2000;
    tick(); jmp_req = 0; exc_req = 1; exc_pc = 32'h300; #1;
    check("t6_exc_ack_flush", exc_ack, 1'b1);
    tick(); exc_req = 0;
    wait_idle(20);
    tick(); #1;
`ifdef FE_REDIRECT_STATS_EN
    check("t6_stat_br", stat_br, 16'd3);
    check("t6_stat_jmp", stat_jmp, 16'd0);
    check("t6_stat_exc", stat_exc, 16'd1);
`endif

    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

endmodule

// File: doc/fe_redirect_ctrl.md
Name: fe_redirect_ctrl

Overview:
- Sequences front-end redirects: arbitrates exception, branch-mispredict and jump redirect requests from the back-end.
- Stalls and flushes the IF/ID, ID/MP and MP/RN FIFOs, waits for the map-table restore, then issues a single-cycle PC override to fetch.
- Sits between the back-end redirect sources and the front-end's branch/jump/exception/stall/pc_override inputs and FIFO resets.

Parameters:
PC_WIDTH, 32, width of redirect PCs
DRAIN_CYCLES, 2, cycles spent in DRAIN after flush (legal range 1..15)
RESTORE_TIMEOUT, 15, maximum cycles in RESTORE waiting for map_restore_done (legal range 1..255)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
exc_req  in  1  exception redirect request, held until acked
exc_pc  in  PC_WIDTH  exception handler PC
br_req  in  1  branch-mispredict redirect request, held until acked
br_pc  in  PC_WIDTH  corrected branch target
jmp_req  in  1  jump redirect request, held until acked
jmp_pc  in  PC_WIDTH  jump target
exc_ack  out  1  combinational; request accepted this cycle
br_ack  out  1  combinational; request accepted this cycle
jmp_ack  out  1  combinational; request accepted this cycle
map_restore_done  in  1  map/busy table restore complete
map_restore_req  out  1  one-cycle pulse starting map restore
fe_stall  out  1  front-end global stall
fifo_flush  out  1  one-cycle synchronous clear of all front-end FIFOs
redir_exception  out  1  one-cycle redirect strobe to fetch
redir_branch  out  1  one-cycle redirect strobe to fetch
redir_jump  out  1  one-cycle redirect strobe to fetch
pc_override  out  PC_WIDTH  latched target; valid while any redir_* is high
busy  out  1  high in every state except IDLE
restore_timeout  out  1  sticky error flag

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - All outputs 0, pc_override 0, latched cause/PC cleared, counters 0, restore_timeout 0.
  - Reset asserted mid-sequence aborts immediately; no pending strobe survives.
- Priority: exception > branch > jump. Exactly one ack per cycle, only in the accepting cycle; the PC and cause are latched on that edge.
- FSM states:
  - IDLE: any request → ack the winner, go to FLUSH.
  - FLUSH: fe_stall=1, fifo_flush=1, load drain counter with DRAIN_CYCLES-1, go to DRAIN.
  - DRAIN: fe_stall=1. Counter decrements each cycle; in the cycle the counter is 0, go to RESTORE.
  - RESTORE: fe_stall=1. map_restore_req=1 in the first RESTORE cycle only. Timeout counter increments each cycle.
    - map_restore_done=1 (including in the first cycle) → go to REDIRECT.
    - Counter reaches RESTORE_TIMEOUT without done → set restore_timeout, go to REDIRECT.
  - REDIRECT: fe_stall=0; exactly one redir_* strobe matching the latched cause, pc_override=latched PC. Go to IDLE.
- Latency (DRAIN_CYCLES=2, done returned immediately): request accepted at cycle N; FLUSH N+1; DRAIN N+2..N+3; RESTORE N+4; REDIRECT N+5. Next acceptance earliest at N+6.
- Preemption:
  - exc_req seen in FLUSH, DRAIN or RESTORE while the latched cause is branch or jump: exc_ack=1, latch exc_pc and cause, next state FLUSH (timeout counter cleared).
  - No preemption in REDIRECT.
  - Branch/jump requests are never acked while busy; requesters hold them.
- map_restore_done outside RESTORE is ignored.
- Simultaneous exc_req+br_req+jmp_req in IDLE: only exc_ack.
- Timeout counter is $clog2(RESTORE_TIMEOUT+1) bits and does not wrap beyond the terminal value.

Optional Feature:
- Macro: FE_REDIRECT_STATS_EN.
- When defined:
  - Adds outputs stat_exc, stat_br, stat_jmp, each 16 bits.
  - Each counts REDIRECT-state strobes of its cause, saturating at 16'hFFFF; preempted requests are not counted.
  - All three reset to 0.
- When undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- br_req=1, br_pc=0x0000_0400 in IDLE, map_restore_done tied 1 → br_ack at N; fifo_flush at N+1 only; fe_stall high N+1..N+4; map_restore_req at N+4; redir_branch=1 with pc_override=0x400 at N+5; busy low at N+6.
- exc_req, br_req and jmp_req asserted together (exc_pc=0x100) → exc_ack only; redir_exception with pc_override=0x100; br_ack asserted after return to IDLE.
- jmp_req accepted, then exc_req (0x200) during DRAIN → exc_ack in that cycle; FLUSH re-entered next cycle; single final strobe redir_exception, pc 0x200; no redir_jump ever.
- map_restore_done held 0, RESTORE_TIMEOUT=15 → 15 cycles in RESTORE, then REDIRECT strobe; restore_timeout=1 and remains 1 until rst_n.
- rst_n pulsed low during RESTORE → all outputs 0 asynchronously; no redir_* strobe afterward; the held request is re-acked after release.
- With FE_REDIRECT_STATS_EN: 3 branch and 1 preempted jump followed by its exception → stat_br=3, stat_jmp=0, stat_exc=1.
